// File: rtl/accumulator_controller.sv
// accumulator_controller
//   Sequences an external WIDTH-bit accumulator register. One command is taken
//   per valid/ready handshake. The next accumulator value is computed from acc_q
//   and the operand and driven onto acc_data, which the register loads on every
//   clock edge. ALU ops finish in one cycle. MUL is an 8-step shift-add.
//   C/Z/V flags are registered alongside the result.
//   Optional feature: define ACCUMULATOR_CONTROLLER_SAT_EN for saturating
//   ADD/SUB/MUL. Flags always come from the unsaturated result.
module accumulator_controller #(
  parameter int WIDTH     = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0] acc_data,
  output logic             busy,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_MUL  = 4'd9,
    OP_CLR  = 4'd10
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               started_q;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic               c_q, c_d;
  logic               z_q, z_d;
  logic               v_q, v_d;

  logic               accept;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic               add_v;
  logic               sub_v;
  logic [2*WIDTH-1:0] mul_addend;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_lost;

  // started_q holds cmd_ready low (and acc_data at zero) until the first edge after reset.
  assign cmd_ready = started_q && (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign accept    = cmd_valid && cmd_ready;

  // Arithmetic in WIDTH+1 bits so the top bit is the carry-out or the borrow (B > A).
  assign add_ext = {1'b0, acc_q} + {1'b0, cmd_operand};
  assign sub_ext = {1'b0, acc_q} - {1'b0, cmd_operand};
  assign add_v   = (acc_q[WIDTH-1] == cmd_operand[WIDTH-1]) &&
                   (add_ext[WIDTH-1] != acc_q[WIDTH-1]);
  assign sub_v   = (acc_q[WIDTH-1] != cmd_operand[WIDTH-1]) &&
                   (sub_ext[WIDTH-1] != acc_q[WIDTH-1]);

  // One multiply step runs in double width. Any bit above WIDTH is product lost to truncation.
  assign mul_addend = b_q[step_q] ? ({{WIDTH{1'b0}}, m_q} << step_q) : '0;
  assign mul_sum    = {{WIDTH{1'b0}}, acc_q} + mul_addend;
  assign mul_lost   = |mul_sum[2*WIDTH-1:WIDTH];

  // Next-state, next-accumulator and flag logic.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d  = state_q;
    m_d      = m_q;
    b_d      = b_q;
    step_d   = step_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    acc_data = acc_q;

    if (!started_q) begin
      acc_data = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            done_d = 1'b1;
            case (cmd_op)
              OP_LOAD: begin
                acc_data = cmd_operand;
                c_d = 1'b0;
                v_d = 1'b0;
                z_d = (cmd_operand == '0);
              end
              OP_ADD: begin
                acc_data = add_ext[WIDTH-1:0];
`ifdef ACCUMULATOR_CONTROLLER_SAT_EN
                if (add_ext[WIDTH]) acc_data = '1;
`endif
                c_d = add_ext[WIDTH];
                v_d = add_v;
                z_d = (add_ext[WIDTH-1:0] == '0);
              end
              OP_SUB: begin
                acc_data = sub_ext[WIDTH-1:0];
`ifdef ACCUMULATOR_CONTROLLER_SAT_EN
                if (sub_ext[WIDTH]) acc_data = '0;
`endif
                c_d = sub_ext[WIDTH];
                v_d = sub_v;
                z_d = (sub_ext[WIDTH-1:0] == '0);
              end
              OP_AND: begin
                acc_data = acc_q & cmd_operand;
                c_d = 1'b0;
                v_d = 1'b0;
                z_d = ((acc_q & cmd_operand) == '0);
              end
              OP_OR: begin
                acc_data = acc_q | cmd_operand;
                c_d = 1'b0;
                v_d = 1'b0;
                z_d = ((acc_q | cmd_operand) == '0);
              end
              OP_XOR: begin
                acc_data = acc_q ^ cmd_operand;
                c_d = 1'b0;
                v_d = 1'b0;
                z_d = ((acc_q ^ cmd_operand) == '0);
              end
              OP_SHL: begin
                acc_data = {acc_q[WIDTH-2:0], 1'b0};
                c_d = acc_q[WIDTH-1];
                v_d = 1'b0;
                z_d = (acc_q[WIDTH-2:0] == '0);
              end
              OP_SHR: begin
                acc_data = {1'b0, acc_q[WIDTH-1:1]};
                c_d = acc_q[0];
                v_d = 1'b0;
                z_d = (acc_q[WIDTH-1:1] == '0);
              end
              OP_MUL: begin
                acc_data = '0;
                m_d      = acc_q;
                b_d      = cmd_operand;
                step_d   = '0;
                sticky_d = 1'b0;
                state_d  = S_MUL;
                done_d   = 1'b0;
              end
              OP_CLR: begin
                acc_data = '0;
                c_d = 1'b0;
                v_d = 1'b0;
                z_d = 1'b1;
              end
              default: begin
                // NOP and illegal opcodes: the accumulator holds and C/V keep their values.
                // Z is refreshed from the held value. This matches its previous value
                // except straight after reset, where the accumulator is 0 but Z was cleared.
                z_d = (acc_q == '0);
              end
            endcase
          end
        end
        S_MUL: begin
          acc_data = mul_sum[WIDTH-1:0];
          sticky_d = sticky_q | mul_lost;
          step_d   = step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            c_d     = sticky_d;
            v_d     = sticky_d;
            z_d     = (mul_sum[WIDTH-1:0] == '0);
`ifdef ACCUMULATOR_CONTROLLER_SAT_EN
            if (sticky_d) acc_data = '1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, multiply context, done pulse and flag registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      m_q       <= '0;
      b_q       <= '0;
      step_q    <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every register sample the pre-edge values together.
      state_q   <= state_d;
      started_q <= 1'b1;
      m_q       <= m_d;
      b_q       <= b_d;
      step_q    <= step_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      c_q       <= c_d;
      z_q       <= z_d;
      v_q       <= v_d;
    end
  end

endmodule

// File: tb/tb_accumulator_controller.sv
// tb_accumulator_controller
//   Directed bench for accumulator_controller. It models the external
//   accumulator register, which loads acc_data on every edge. Expected values
//   are hand-computed. Defining ACCUMULATOR_CONTROLLER_SAT_EN selects the
//   saturating expectations.
module tb_accumulator_controller;

  logic       clk = 1'b0;
  logic       nReset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] acc_q = 8'hA5;
  logic [7:0] acc_data;
  logic       busy;
  logic       done;
  logic       flag_c;
  logic       flag_z;
  logic       flag_v;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] NOP = 4'd0, LOAD = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, XOR_ = 4'd6, SHL = 4'd7, SHR = 4'd8, MUL = 4'd9,
                         CLR = 4'd10;

`ifdef ACCUMULATOR_CONTROLLER_SAT_EN
  localparam logic [7:0] E_ADD = 8'hFF, E_SUB = 8'h00, E_MUL5 = 8'hFF, E_POST = 8'hFF;
  localparam logic       E_POST_C = 1'b1, E_POST_Z = 1'b1;
`else
  localparam logic [7:0] E_ADD = 8'h10, E_SUB = 8'hFE, E_MUL5 = 8'h00, E_POST = 8'h01;
  localparam logic       E_POST_C = 1'b0, E_POST_Z = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  // Applied back to back, starting from acc = 0.
  localparam vec_t VECS [20] = '{
    '{LOAD,  8'hF0, 8'hF0,  1'b0, 1'b0, 1'b0},
    '{ADD,   8'h20, E_ADD,  1'b1, 1'b0, 1'b0},
    '{LOAD,  8'h7F, 8'h7F,  1'b0, 1'b0, 1'b0},
    '{ADD,   8'h01, 8'h80,  1'b0, 1'b0, 1'b1},
    '{LOAD,  8'h05, 8'h05,  1'b0, 1'b0, 1'b0},
    '{SUB,   8'h07, E_SUB,  1'b1, 1'b0, 1'b0},
    '{LOAD,  8'h80, 8'h80,  1'b0, 1'b0, 1'b0},
    '{SUB,   8'h01, 8'h7F,  1'b0, 1'b0, 1'b1},
    '{AND_,  8'h0F, 8'h0F,  1'b0, 1'b0, 1'b0},
    '{LOAD,  8'h81, 8'h81,  1'b0, 1'b0, 1'b0},
    '{SHL,   8'h00, 8'h02,  1'b1, 1'b0, 1'b0},
    '{4'd12, 8'hFF, 8'h02,  1'b1, 1'b0, 1'b0},
    '{SHR,   8'h00, 8'h01,  1'b0, 1'b0, 1'b0},
    '{SHR,   8'h00, 8'h00,  1'b1, 1'b1, 1'b0},
    '{NOP,   8'h33, 8'h00,  1'b1, 1'b1, 1'b0},
    '{LOAD,  8'h0F, 8'h0F,  1'b0, 1'b0, 1'b0},
    '{OR_,   8'hF0, 8'hFF,  1'b0, 1'b0, 1'b0},
    '{XOR_,  8'hFF, 8'h00,  1'b0, 1'b1, 1'b0},
    '{LOAD,  8'h3C, 8'h3C,  1'b0, 1'b0, 1'b0},
    '{CLR,   8'h55, 8'h00,  1'b0, 1'b1, 1'b0}
  };

  accumulator_controller #(.WIDTH(8), .MUL_STEPS(8)) dut (
    .clk         (clk),
    .nReset      (nReset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .acc_q       (acc_q),
    .acc_data    (acc_data),
    .busy        (busy),
    .done        (done),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_v      (flag_v)
  );

  always #5 clk = ~clk;

  // External accumulator register: loads acc_data on every rising edge.
  always @(posedge clk) acc_q <= acc_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, check the combinational result,
  // then let the edge take it. Returns 1 ns after the accepting edge with valid low.
  task automatic issue(input logic [3:0] op, input logic [7:0] b, input logic [7:0] exp_comb);
    int n;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = b;
    #1;
    n = 0;
    while (!cmd_ready && n < 30) begin
      step();
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    check("acc_data_hs", 32'(acc_data), 32'(exp_comb));
    step();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  initial begin
    int n;
    int pulses;
    nReset      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = NOP;
    cmd_operand = 8'h00;

    // 1: reset values, ready one cycle after release, NOP on zero.
    repeat (3) step();
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_acc_data", 32'(acc_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
    check("rst_acc_q", 32'(acc_q), 32'd0);
    nReset = 1'b1;
    #1;
    check("rel_ready_low", 32'(cmd_ready), 32'd0);
    step();
    check("rel_ready_high", 32'(cmd_ready), 32'd1);
    issue(NOP, 8'h33, 8'h00);
    check("nop_done", 32'(done), 32'd1);
    check("nop_acc", 32'(acc_q), 32'd0);
    check("nop_z", 32'(flag_z), 32'd1);
    step();
    check("nop_done_clr", 32'(done), 32'd0);

    // 2/3: single-cycle ops, back to back (each accepted in the previous done cycle).
    for (int i = 0; i < 20; i++) begin
      issue(VECS[i].op, VECS[i].b, VECS[i].acc);
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
      check($sformatf("v%0d_acc", i), 32'(acc_q), 32'(VECS[i].acc));
      check($sformatf("v%0d_czv", i), {29'd0, flag_c, flag_z, flag_v},
            {29'd0, VECS[i].c, VECS[i].z, VECS[i].v});
    end

    // 4: 13 * 11 = 143, busy for 8 cycles, done after the ninth edge.
    issue(LOAD, 8'h0D, 8'h0D);
    issue(MUL, 8'h0B, 8'h00);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mul4_busy%0d", k), {30'd0, busy, cmd_ready}, 32'd2);
      check($sformatf("mul4_nodone%0d", k), 32'(done), 32'd0);
      step();
    end
    check("mul4_done", 32'(done), 32'd1);
    check("mul4_busy_end", 32'(busy), 32'd0);
    check("mul4_acc", 32'(acc_q), 32'h8F);
    check("mul4_czv", {29'd0, flag_c, flag_z, flag_v}, 32'd0);

    // 5: 0x20 * 0x10 overflows; a command held during MUL is taken in the done cycle.
    issue(LOAD, 8'h20, 8'h20);
    issue(MUL, 8'h10, 8'h00);
    step();
    step();
    cmd_valid   = 1'b1;
    cmd_op      = ADD;
    cmd_operand = 8'h01;
    #1;
    n = 0;
    while (!done && n < 20) begin
      check("mul5_held_ready", 32'(cmd_ready), 32'd0);
      step();
      n++;
    end
    check("mul5_latency", 32'(n), 32'd6);
    check("mul5_ready", 32'(cmd_ready), 32'd1);
    check("mul5_acc", 32'(acc_q), 32'(E_MUL5));
    check("mul5_czv", {29'd0, flag_c, flag_z, flag_v}, 32'd7);
    step();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    check("post_done", 32'(done), 32'd1);
    check("post_acc", 32'(acc_q), 32'(E_POST));
    check("post_cz", {30'd0, flag_c, flag_z}, {30'd0, E_POST_C, E_POST_Z});

    // 6: reset in the middle of a multiply (C set beforehand).
    issue(LOAD, 8'h05, 8'h05);
    issue(SUB, 8'h07, E_SUB);
    issue(MUL, 8'h03, 8'h00);
    repeat (4) step();
    check("abort_busy_pre", 32'(busy), 32'd1);
    nReset = 1'b0;
    #1;
    check("abort_acc_data", 32'(acc_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
    repeat (2) step();
    nReset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_acc_after", 32'(acc_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
